// File: rtl/banzai_bridge_pkg.sv
// Shared types and helpers for the banzAI AXI4-Lite to SRAM bridge.
// FSM state encoding, arbitration priority, AXI response codes.
package banzai_bridge_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WREQ,
      BRESP,
      RREQ,
      RWAIT,
      RRESP
   } state_e;

   typedef enum logic {
      PRIO_W = 1'b0,
      PRIO_R = 1'b1
   } prio_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Byte offset within the window -> word offset.
   function automatic logic [63:0] word_off(
      input logic [63:0] byte_off,
      input int unsigned lsb
   );
      return byte_off >> lsb;
   endfunction

endpackage

// File: rtl/banzai_axil_sram_bridge.sv
// AXI4-Lite slave to single-word SRAM req/gnt bridge, one transaction in flight.
// Define BANZAI_BRIDGE_ERR_EN to answer out-of-window accesses with SLVERR.
module banzai_axil_sram_bridge
   import banzai_bridge_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    MEM_AW     = 12,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [ADDR_WIDTH-1:0]     s_awaddr,
   input  logic [2:0]                s_awprot,
   input  logic                      s_awvalid,
   output logic                      s_awready,
   input  logic [DATA_WIDTH-1:0]     s_wdata,
   input  logic [DATA_WIDTH/8-1:0]   s_wstrb,
   input  logic                      s_wvalid,
   output logic                      s_wready,
   output logic [1:0]                s_bresp,
   output logic                      s_bvalid,
   input  logic                      s_bready,
   input  logic [ADDR_WIDTH-1:0]     s_araddr,
   input  logic [2:0]                s_arprot,
   input  logic                      s_arvalid,
   output logic                      s_arready,
   output logic [DATA_WIDTH-1:0]     s_rdata,
   output logic [1:0]                s_rresp,
   output logic                      s_rvalid,
   input  logic                      s_rready,
   output logic                      mem_req_o,
   input  logic                      mem_gnt_i,
   output logic                      mem_we_o,
   output logic [MEM_AW-1:0]         mem_addr_o,
   output logic [DATA_WIDTH-1:0]     mem_wdata_o,
   output logic [DATA_WIDTH/8-1:0]   mem_be_o,
   input  logic                      mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

   localparam int          BW  = DATA_WIDTH / 8;
   localparam int unsigned LSB = $clog2(BW);
   localparam int unsigned WIN = MEM_AW + LSB;

   state_e state, state_n;
   prio_e  prio;

   logic                  we_q;
   logic [MEM_AW-1:0]     addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [BW-1:0]         be_q;
   logic [1:0]            resp_q;
   logic [DATA_WIDTH-1:0] rdata_q;

   logic                  w_pend;
   logic                  take_w;
   logic                  take_r;
   logic                  prio_flip;
   logic                  aw_err;
   logic                  ar_err;
   logic [ADDR_WIDTH-1:0] aw_off;
   logic [ADDR_WIDTH-1:0] ar_off;
   logic [63:0]           aw_word;
   logic [63:0]           ar_word;
   logic                  unused;

   assign w_pend  = s_awvalid && s_wvalid;
   assign aw_off  = s_awaddr - BASE_ADDR;
   assign ar_off  = s_araddr - BASE_ADDR;
   assign aw_word = word_off(64'(aw_off), LSB);
   assign ar_word = word_off(64'(ar_off), LSB);

`ifdef BANZAI_BRIDGE_ERR_EN
   assign aw_err = |(64'(aw_off) >> WIN);
   assign ar_err = |(64'(ar_off) >> WIN);
`else
   assign aw_err = 1'b0;
   assign ar_err = 1'b0;
`endif

   assign unused = ^{s_awprot, s_arprot, aw_word, ar_word, WIN};

   assign mem_we_o    = we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign mem_be_o    = be_q;
   assign s_bresp     = resp_q;
   assign s_rresp     = resp_q;
   assign s_rdata     = rdata_q;

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= IDLE;
      else         state <= state_n;
   end

   // Arbitration, handshakes and next state.
   always_comb begin
      state_n   = state;
      take_w    = 1'b0;
      take_r    = 1'b0;
      prio_flip = 1'b0;
      s_awready = 1'b0;
      s_wready  = 1'b0;
      s_arready = 1'b0;
      s_bvalid  = 1'b0;
      s_rvalid  = 1'b0;
      mem_req_o = 1'b0;
      unique case (state)
         IDLE: begin
            if (rst_ni) begin
               if (w_pend && (!s_arvalid || prio == PRIO_W))
                  take_w = 1'b1;
               else if (s_arvalid)
                  take_r = 1'b1;
               prio_flip = w_pend && s_arvalid;
            end
            s_awready = take_w;
            s_wready  = take_w;
            s_arready = take_r;
            if (take_w) state_n = aw_err ? BRESP : WREQ;
            if (take_r) state_n = ar_err ? RRESP : RREQ;
         end
         WREQ: begin
            mem_req_o = 1'b1;
            if (mem_gnt_i) state_n = BRESP;
         end
         BRESP: begin
            s_bvalid = 1'b1;
            if (s_bready) state_n = IDLE;
         end
         RREQ: begin
            mem_req_o = 1'b1;
            if (mem_gnt_i) state_n = RWAIT;
         end
         RWAIT: begin
            if (mem_rvalid_i) state_n = RRESP;
         end
         RRESP: begin
            s_rvalid = 1'b1;
            if (s_rready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Request/response holding registers and round-robin priority.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prio    <= PRIO_W;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         resp_q  <= RESP_OKAY;
         rdata_q <= '0;
      end else begin
         if (prio_flip)
            prio <= (prio == PRIO_W) ? PRIO_R : PRIO_W;
         if (take_w) begin
            we_q    <= 1'b1;
            addr_q  <= aw_word[MEM_AW-1:0];
            wdata_q <= s_wdata;
            be_q    <= s_wstrb;
            resp_q  <= aw_err ? RESP_SLVERR : RESP_OKAY;
         end
         if (take_r) begin
            we_q    <= 1'b0;
            addr_q  <= ar_word[MEM_AW-1:0];
            resp_q  <= ar_err ? RESP_SLVERR : RESP_OKAY;
            rdata_q <= '0;
         end
         if (state == RWAIT && mem_rvalid_i)
            rdata_q <= mem_rdata_i;
      end
   end

endmodule

// File: tb/tb_banzai_axil_sram_bridge.sv
// Directed bench for banzai_axil_sram_bridge with a 1-cycle SRAM model.
// Expectations follow BANZAI_BRIDGE_ERR_EN when it is defined.
module tb_banzai_axil_sram_bridge;

   logic        clk;
   logic        rst_n;
   logic [31:0] awaddr;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [31:0] araddr;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic        mem_req;
   logic        mem_gnt;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_rv;
   logic [31:0] mem_rd;

   logic        gnt_en;
   logic        hold_rv;
   logic        force_rv;
   logic [31:0] mem [0:4095] = '{default: 32'h0};

   int checks;
   int failures;

   banzai_axil_sram_bridge dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .s_awaddr    (awaddr),
      .s_awprot    (awprot),
      .s_awvalid   (awvalid),
      .s_awready   (awready),
      .s_wdata     (wdata),
      .s_wstrb     (wstrb),
      .s_wvalid    (wvalid),
      .s_wready    (wready),
      .s_bresp     (bresp),
      .s_bvalid    (bvalid),
      .s_bready    (bready),
      .s_araddr    (araddr),
      .s_arprot    (arprot),
      .s_arvalid   (arvalid),
      .s_arready   (arready),
      .s_rdata     (rdata),
      .s_rresp     (rresp),
      .s_rvalid    (rvalid),
      .s_rready    (rready),
      .mem_req_o   (mem_req),
      .mem_gnt_i   (mem_gnt),
      .mem_we_o    (mem_we),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .mem_be_o    (mem_be),
      .mem_rvalid_i(mem_rv),
      .mem_rdata_i (mem_rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_gnt = mem_req && gnt_en;

   // SRAM model: write on grant, read data one cycle after grant.
   always @(posedge clk) begin
      if (force_rv) begin
         mem_rv <= 1'b1;
         mem_rd <= 32'h5A5A5A5A;
      end else if (mem_req && mem_gnt && !mem_we && !hold_rv) begin
         mem_rv <= 1'b1;
         mem_rd <= mem[mem_addr];
      end else begin
         mem_rv <= 1'b0;
      end
      if (mem_req && mem_gnt && mem_we)
         for (int b = 0; b < 4; b++)
            if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
   end

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp,
                           output int lat, output logic [11:0] maddr,
                           output logic [3:0] mbe);
      bit acc;
      bit seen;
      lat   = -1;
      resp  = 2'b11;
      maddr = '1;
      mbe   = 'x;
      seen  = 0;
      @(posedge clk); #1;
      awaddr  = a;
      wdata   = d;
      wstrb   = s;
      awvalid = 1;
      wvalid  = 1;
      bready  = 1;
      acc     = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (awready && wready) begin acc = 1; break; end
      end
      @(posedge clk); #1;
      awvalid = 0;
      wvalid  = 0;
      if (!acc) begin check("wr_accept_timeout", 0, 1); return; end
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (mem_req && !seen) begin seen = 1; maddr = mem_addr; mbe = mem_be; end
         if (bvalid) begin lat = k; resp = bresp; break; end
      end
      if (lat < 0) check("wr_resp_timeout", 0, 1);
   endtask

   task automatic do_read(input logic [31:0] a, output logic [1:0] resp,
                          output logic [31:0] d, output int lat,
                          output logic [11:0] maddr, output bit seen);
      bit acc;
      lat   = -1;
      resp  = 2'b11;
      d     = 32'hFFFF_FFFF;
      maddr = '1;
      seen  = 0;
      @(posedge clk); #1;
      araddr  = a;
      arvalid = 1;
      rready  = 1;
      acc     = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (arready) begin acc = 1; break; end
      end
      @(posedge clk); #1;
      arvalid = 0;
      if (!acc) begin check("rd_accept_timeout", 0, 1); return; end
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (mem_req && !seen) begin seen = 1; maddr = mem_addr; end
         if (rvalid) begin lat = k; resp = rresp; d = rdata; break; end
      end
      if (lat < 0) check("rd_resp_timeout", 0, 1);
   endtask

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [11:0] eaddr;
      logic [31:0] erdata;
      int          elat;
   } vec_t;

   vec_t        vecs [9];
   logic [1:0]  r_resp;
   logic [31:0] r_data;
   int          r_lat;
   logic [11:0] r_maddr;
   logic [3:0]  r_be;
   bit          r_seen;
   bit          bad;
   bit          wa, ra, bg, rg;
   int          first;
   logic [1:0]  br, rr;
   logic [31:0] rdv;
   logic [31:0] hold_d;

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 0;
      awaddr   = '0;
      awprot   = '0;
      awvalid  = 0;
      wdata    = '0;
      wstrb    = '0;
      wvalid   = 0;
      bready   = 1;
      araddr   = '0;
      arprot   = 3'b101;
      arvalid  = 0;
      rready   = 1;
      gnt_en   = 1;
      hold_rv  = 0;
      force_rv = 0;

      vecs[0] = '{1, 32'h00, 32'h11223344, 4'hF, 12'd0,  32'h0, 2};
      vecs[1] = '{1, 32'h10, 32'hDEADBEEF, 4'hF, 12'd4,  32'h0, 2};
      vecs[2] = '{1, 32'h24, 32'h12345678, 4'h3, 12'd9,  32'h0, 2};
      vecs[3] = '{1, 32'h40, 32'hAAAA5555, 4'h0, 12'd16, 32'h0, 2};
      vecs[4] = '{1, 32'h08, 32'hCAFEF00D, 4'hF, 12'd2,  32'h0, 2};
      vecs[5] = '{0, 32'h10, 32'h0, 4'h0, 12'd4,  32'hDEADBEEF, 3};
      vecs[6] = '{0, 32'h27, 32'h0, 4'h0, 12'd9,  32'h00005678, 3};
      vecs[7] = '{0, 32'h40, 32'h0, 4'h0, 12'd16, 32'h00000000, 3};
      vecs[8] = '{0, 32'h0A, 32'h0, 4'h0, 12'd2,  32'hCAFEF00D, 3};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_handshakes", {awready, wready, arready, bvalid, rvalid, mem_req},
            6'b0);
      check("rst_data", {mem_we, mem_addr, mem_be, mem_wdata, bresp, rresp}, 0);
      check("rst_rdata", rdata, 0);
      @(posedge clk); #1;
      rst_n = 1;

      // Table-driven single transactions
      for (int i = 0; i < 9; i++) begin
         if (vecs[i].wr) begin
            do_write(vecs[i].addr, vecs[i].data, vecs[i].strb,
                     r_resp, r_lat, r_maddr, r_be);
            check($sformatf("v%0d_wr_addr", i), r_maddr, vecs[i].eaddr);
            check($sformatf("v%0d_wr_be", i), r_be, vecs[i].strb);
            check($sformatf("v%0d_bresp", i), r_resp, 2'b00);
            check($sformatf("v%0d_wr_lat", i), r_lat, vecs[i].elat);
         end else begin
            do_read(vecs[i].addr, r_resp, r_data, r_lat, r_maddr, r_seen);
            check($sformatf("v%0d_rd_addr", i), r_maddr, vecs[i].eaddr);
            check($sformatf("v%0d_rdata", i), r_data, vecs[i].erdata);
            check($sformatf("v%0d_rresp", i), r_resp, 2'b00);
            check($sformatf("v%0d_rd_lat", i), r_lat, vecs[i].elat);
         end
      end

      // Round-robin: write and read pending together, four rounds
      for (int rd = 0; rd < 4; rd++) begin
         @(posedge clk); #1;
         awaddr  = 32'h100 + 32'(rd * 4);
         wdata   = 32'hA000_0000 | 32'(rd);
         wstrb   = 4'hF;
         awvalid = 1;
         wvalid  = 1;
         araddr  = 32'h10;
         arvalid = 1;
         bready  = 1;
         rready  = 1;
         wa = 0; ra = 0; bg = 0; rg = 0; first = 0;
         br = 2'b11; rr = 2'b11; rdv = '0;
         for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (awready && wready) begin wa = 1; if (first == 0) first = 1; end
            if (arready) begin ra = 1; if (first == 0) first = 2; end
            if (bvalid) begin bg = 1; br = bresp; end
            if (rvalid) begin rg = 1; rr = rresp; rdv = rdata; end
            @(posedge clk); #1;
            if (wa) begin awvalid = 0; wvalid = 0; end
            if (ra) arvalid = 0;
            if (bg && rg) break;
         end
         awvalid = 0; wvalid = 0; arvalid = 0;
         check($sformatf("arb%0d_first", rd), first, (rd % 2 == 0) ? 1 : 2);
         check($sformatf("arb%0d_bresp", rd), br, 2'b00);
         check($sformatf("arb%0d_rresp", rd), rr, 2'b00);
         check($sformatf("arb%0d_rdata", rd), rdv, 32'hDEADBEEF);
      end

      // Delayed grant and stalled rready on a read of BASE+0x8
      gnt_en = 0;
      @(posedge clk); #1;
      araddr  = 32'h08;
      arvalid = 1;
      rready  = 0;
      @(negedge clk);
      check("gd_accept", arready, 1);
      @(posedge clk); #1;
      arvalid = 0;
      bad = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (!mem_req || mem_we || mem_addr != 12'd2) bad = 1;
      end
      check("gd_req_stable", bad, 0);
      @(posedge clk); #1;
      gnt_en = 1;
      bad = 1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (rvalid) begin bad = 0; break; end
      end
      check("gd_rvalid_seen", bad, 0);
      hold_d = rdata;
      bad = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (!rvalid || rdata != hold_d || rresp != 2'b00) bad = 1;
      end
      check("gd_rdata_hold", bad, 0);
      check("gd_rdata", hold_d, 32'hCAFEF00D);
      @(posedge clk); #1;
      rready = 1;
      @(posedge clk); #1;
      check("gd_rvalid_drop", rvalid, 0);

      // AW without W must stall; joint acceptance once W arrives
      @(posedge clk); #1;
      awaddr  = 32'h30;
      awvalid = 1;
      wvalid  = 0;
      bready  = 1;
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (awready || wready || mem_req) bad = 1;
      end
      check("aw_only_stall", bad, 0);
      @(posedge clk); #1;
      wdata  = 32'h0BADCAFE;
      wstrb  = 4'hF;
      wvalid = 1;
      @(negedge clk);
      check("aw_w_joint", {awready, wready}, 2'b11);
      @(posedge clk); #1;
      awvalid = 0;
      wvalid  = 0;
      bad = 1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (bvalid) begin bad = (bresp != 2'b00); break; end
      end
      check("aw_w_bresp", bad, 0);
      do_read(32'h30, r_resp, r_data, r_lat, r_maddr, r_seen);
      check("aw_w_readback", r_data, 32'h0BADCAFE);

      // Access just past the window
      do_read(32'h4000, r_resp, r_data, r_lat, r_maddr, r_seen);
`ifdef BANZAI_BRIDGE_ERR_EN
      check("oor_rresp", r_resp, 2'b10);
      check("oor_rdata", r_data, 0);
      check("oor_no_req", r_seen, 0);
`else
      check("oor_rresp", r_resp, 2'b00);
      check("oor_wrap_addr", r_maddr, 12'd0);
      check("oor_rdata", r_data, 32'h11223344);
`endif

      // Reset during RWAIT, then a stray late rvalid
      hold_rv = 1;
      @(posedge clk); #1;
      araddr  = 32'h10;
      arvalid = 1;
      rready  = 1;
      @(negedge clk);
      check("rst6_accept", arready, 1);
      @(posedge clk); #1;
      arvalid = 0;
      @(negedge clk);
      check("rst6_req", mem_req, 1);
      @(negedge clk);
      rst_n = 0;
      #1;
      check("rst6_hs", {rvalid, mem_req, arready, awready, bvalid}, 5'b0);
      check("rst6_addr", mem_addr, 0);
      check("rst6_rdata", rdata, 0);
      @(posedge clk); #1;
      rst_n    = 1;
      hold_rv  = 0;
      force_rv = 1;
      @(posedge clk); #1;
      force_rv = 0;
      bad = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (rvalid || mem_req || rdata != 0) bad = 1;
      end
      check("rst6_no_rvalid", bad, 0);
      do_write(32'h0C, 32'h55AA55AA, 4'hF, r_resp, r_lat, r_maddr, r_be);
      check("rst6_idle_wr_lat", r_lat, 2);
      check("rst6_idle_wr_addr", r_maddr, 12'd3);

      @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
